datapath_core: RTL

- Execution end of the 16-bit control-word interface. Accepts one control word per clock, reads two operands from an 8-entry register file and computes a result in a function unit.
- Writes the result, or external data, back to the register file and latches C/V/N/Z status flags.
- Sits below the mode/sequencer logic of the lab top level. It drives the Data_out and Address_out buses, which feed the seven-segment display path.

---
 rtl/datapath_core.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/datapath_core.sv
// Execution datapath: 8-entry register file, operand muxes, function unit and status flags,
// driven by one 16-bit control word per clock.
module datapath_core #(
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [15:0]       control_word,
    input  logic              cw_valid,
    input  logic [DATA_W-1:0] Data_in,
    input  logic [DATA_W-1:0] constant_in,
    output logic [DATA_W-1:0] Data_out,
    output logic [DATA_W-1:0] Address_out,
    output logic              C,
    output logic              V,
    output logic              N,
    output logic              Z
);

    localparam int unsigned NumRegs = 8;

    typedef enum logic [3:0] {
        FnMovA  = 4'b0000,
        FnInc   = 4'b0001,
        FnAdd   = 4'b0010,
        FnAddC  = 4'b0011,
        FnAddNb = 4'b0100,
        FnSub   = 4'b0101,
        FnDec   = 4'b0110,
        FnMovA2 = 4'b0111,
        FnAnd   = 4'b1000,
        FnOr    = 4'b1001,
        FnXor   = 4'b1010,
        FnNot   = 4'b1011,
        FnMovB  = 4'b1100,
        FnShr   = 4'b1101,
        FnShl   = 4'b1110,
        FnRsvd  = 4'b1111
    } fn_e;

    // Control word fields
    logic [2:0] da;
    logic [2:0] aa;
    logic [2:0] ba;
    logic       mb;
    fn_e        fs;
    logic       md;
    logic       rw;

    assign da = control_word[15:13];
    assign aa = control_word[12:10];
    assign ba = control_word[9:7];
    assign mb = control_word[6];
    assign fs = fn_e'(control_word[5:2]);
    assign md = control_word[1];
    assign rw = control_word[0];

    logic [DATA_W-1:0] regs_q [NumRegs];

    logic [DATA_W-1:0] bus_a;
    logic [DATA_W-1:0] bus_b;
    logic [DATA_W-1:0] bus_d;

    assign bus_a       = regs_q[aa];
    assign bus_b       = mb ? constant_in : regs_q[ba];
    assign Address_out = bus_a;
    assign Data_out    = bus_b;

    // Shared adder: every arithmetic code is A + add_b + add_cin in DATA_W+1 bits
    logic [DATA_W-1:0] add_b;
    logic              add_cin;
    logic [DATA_W:0]   add_sum;
    logic              is_arith;

    always_comb begin
        add_b    = '0;
        add_cin  = 1'b0;
        is_arith = 1'b1;
        unique case (fs)
            FnInc:   add_cin = 1'b1;
            FnAdd:   add_b   = bus_b;
            FnAddC: begin
                add_b   = bus_b;
                add_cin = 1'b1;
            end
            FnAddNb: add_b   = ~bus_b;
            FnSub: begin
                add_b   = ~bus_b;
                add_cin = 1'b1;
            end
            FnDec:   add_b   = '1;
            default: is_arith = 1'b0;
        endcase
    end

    assign add_sum = {1'b0, bus_a} + {1'b0, add_b} + {{DATA_W{1'b0}}, add_cin};

    // Increment adds 1 as a positive operand, so its overflow sign reference is 0
    logic op_b_sign;
    assign op_b_sign = (fs == FnInc) ? 1'b0 : add_b[DATA_W-1];

    logic [DATA_W-1:0] fn_f;
    logic              fn_c;
    logic              fn_v;
    logic              fn_n;
    logic              fn_z;

    always_comb begin
        fn_f = '0;
        fn_c = 1'b0;
        fn_v = 1'b0;
        unique case (fs)
            FnMovA, FnMovA2: fn_f = bus_a;
            FnInc, FnAdd, FnAddC, FnAddNb, FnSub, FnDec: begin
                fn_f = add_sum[DATA_W-1:0];
                fn_c = add_sum[DATA_W];
                fn_v = (bus_a[DATA_W-1] == op_b_sign) &&
                       (add_sum[DATA_W-1] != bus_a[DATA_W-1]);
            end
            FnAnd:   fn_f = bus_a & bus_b;
            FnOr:    fn_f = bus_a | bus_b;
            FnXor:   fn_f = bus_a ^ bus_b;
            FnNot:   fn_f = ~bus_a;
            FnMovB:  fn_f = bus_b;
            FnShr: begin
                fn_f = {1'b0, bus_b[DATA_W-1:1]};
                fn_c = bus_b[0];
            end
            FnShl: begin
                fn_f = {bus_b[DATA_W-2:0], 1'b0};
                fn_c = bus_b[DATA_W-1];
            end
            FnRsvd:  fn_f = '0;
            default: fn_f = '0;
        endcase
    end

    // Reserved code forces Z low even though the result is zero
    assign fn_n = fn_f[DATA_W-1];
    assign fn_z = (fs == FnRsvd) ? 1'b0 : (fn_f == '0);

    assign bus_d = md ? Data_in : fn_f;

    logic reg_we;
    logic flag_we;

    assign reg_we  = cw_valid && rw;
    assign flag_we = cw_valid && !md;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NumRegs; i++) begin
                regs_q[i] <= '0;
            end
        end else if (reg_we) begin
            regs_q[da] <= bus_d;
        end
    end

    logic c_q, v_q, n_q, z_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            c_q <= 1'b0;
            v_q <= 1'b0;
            n_q <= 1'b0;
            z_q <= 1'b0;
        end else if (flag_we) begin
            c_q <= fn_c;
            v_q <= fn_v;
            n_q <= fn_n;
            z_q <= fn_z;
        end
    end

    assign C = c_q;
    assign V = v_q;
    assign N = n_q;
    assign Z = z_q;

    // is_arith documents the adder's users; kept observable for debug
    logic unused_is_arith;
    assign unused_is_arith = is_arith;

endmodule
